sar_adc_ctrl: RTL and testbench

Successive-approximation controller that turns the PWM DAC plus an external comparator into an ADC. It drives the DAC's `duty_cycle` input with trial codes and uses the DAC's `zero` pulse as its settling timebase. It samples the comparator after each trial and produces a `WIDTH`-bit conversion result with a one-cycle `done` strobe. The block sits directly upstream of the PWM DAC and feeds the display/scaling logic downstream.

---
 rtl/sar_adc_pkg.sv | 14 +
 rtl/sync_2ff.sv | 22 ++
 rtl/sar_adc_ctrl.sv | 139 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int AVG_CONVERSIONS = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so meta and q stay two distinct flops in series.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller driving a PWM DAC and sampling an external comparator.
// Optional build macro SAR_ADC_AVG_EN: average four conversions per start.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH          = 9,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             zero,
    input  logic             comp_in,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_PERIODS);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] sample_trial;
    logic [WIDTH-1:0] final_code;
    logic [3:0]       edge_cnt;
    logic             zero_q;
    logic             zero_edge;
    logic             comp_s;
    logic             last_conv;

    sync_2ff u_comp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (comp_in),
        .q     (comp_s)
    );

    assign zero_edge = zero & ~zero_q;

    // In SAMPLE, duty_cycle already holds trial with the bit under test set.
    assign sample_trial = comp_s ? duty_cycle : trial;

`ifdef SAR_ADC_AVG_EN
    localparam int               CNT_W    = $clog2(AVG_CONVERSIONS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AVG_CONVERSIONS - 1);

    logic [CNT_W-1:0] conv_cnt;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_next;

    assign acc_next   = acc + (WIDTH + 2)'(sample_trial);
    assign last_conv  = (conv_cnt == CNT_LAST);
    assign final_code = acc_next[WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_cnt <= '0;
            acc      <= '0;
        end else if (state == IDLE && start) begin
            conv_cnt <= '0;
            acc      <= '0;
        end else if (state == SAMPLE && bit_idx == '0) begin
            conv_cnt <= conv_cnt + 1'b1;
            acc      <= acc_next;
        end
    end
`else
    assign last_conv  = 1'b1;
    assign final_code = sample_trial;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            trial      <= '0;
            edge_cnt   <= '0;
            zero_q     <= 1'b0;
            duty_cycle <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            zero_q <= zero;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_idx <= IDX_TOP;
                        trial   <= '0;
                        busy    <= 1'b1;
                        state   <= SET;
                    end
                end
                SET: begin
                    duty_cycle <= trial | (WIDTH'(1) << bit_idx);
                    edge_cnt   <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (zero_edge) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt + 4'd1 == SETTLE_LAST)
                            state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    trial <= sample_trial;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        state   <= SET;
                    end else if (!last_conv) begin
                        bit_idx <= IDX_TOP;
                        trial   <= '0;
                        state   <= SET;
                    end else begin
                        // Result, strobe and busy drop land together so done is high in DONE.
                        result     <= final_code;
                        duty_cycle <= final_code;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with a behavioural 9-bit PWM DAC counter and ideal comparator.
module tb_sar_adc_ctrl;
    import sar_adc_pkg::*;

    localparam int WIDTH  = 9;
    localparam int SETTLE = 2;
    localparam int FAST_BUDGET = 20000;
    localparam int SLOW_BUDGET = 60000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             zero;
    logic             comp_in;
    logic [WIDTH-1:0] duty_cycle;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    int               target;
    logic             dac_slow;
    logic [1:0]       dac_div;
    logic [WIDTH-1:0] dac_cnt;
    logic             dac_en;

    int               sb[$];
    logic [WIDTH-1:0] trial_log[$];
    logic [WIDTH-1:0] prev_dc;
    int               done_count  = 0;
    int               conv_starts = 0;

    always #5 clk = ~clk;

    sar_adc_ctrl #(
        .WIDTH          (WIDTH),
        .SETTLE_PERIODS (SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .zero       (zero),
        .comp_in    (comp_in),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // PWM DAC counter with count_value 511; slow mode advances once every 4 clocks.
    assign dac_en  = dac_slow ? (dac_div == 2'd0) : 1'b1;
    assign zero    = (dac_cnt == '0);
    assign comp_in = (int'(duty_cycle) <= target);

    always @(posedge clk) begin
        if (reset) begin
            dac_cnt <= '0;
            dac_div <= '0;
        end else begin
            dac_div <= dac_div + 2'd1;
            if (dac_en)
                dac_cnt <= (dac_cnt == 9'd511) ? '0 : dac_cnt + 9'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: logs trial codes and scores each done against the queue.
    always @(negedge clk) begin
        if (!reset && busy && duty_cycle != prev_dc)
            trial_log.push_back(duty_cycle);
        if (!reset && duty_cycle == 9'd256 && prev_dc != 9'd256)
            conv_starts++;
        prev_dc = duty_cycle;
        if (done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                int exp_v;
                exp_v = sb.pop_front();
                check("result", 32'(result), exp_v);
                check("duty_at_done", 32'(duty_cycle), exp_v);
                check("busy_at_done", 32'(busy), 0);
            end
        end
    end

    task automatic start_conv(input int tgt, input int exp_v);
        target = tgt;
        trial_log.delete();
        sb.push_back(exp_v);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic finish_conv(input int d0, input int budget, output int lat);
        lat = 0;
        while (done_count == d0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (done_count == d0)
            check("done_timeout", 0, 1);
        repeat (20) @(negedge clk);
        check("done_once", 32'(done_count - d0), 1);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic wait_trials(input int n);
        int k = 0;
        while (trial_log.size() < n && k < FAST_BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (trial_log.size() < n)
            check("trial_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_duty"}, 32'(duty_cycle), 0);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fsm"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        int d0;
        int lat;
        reset    = 1'b1;
        start    = 1'b0;
        target   = 0;
        dac_slow = 1'b0;
        prev_dc  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

`ifdef SAR_ADC_AVG_EN
        begin
            int base;
            int k;
            base = conv_starts;
            d0   = done_count;
            start_conv(100, 101);
            for (int i = 1; i < 4; i++) begin
                k = 0;
                while (conv_starts < base + i + 1 && k < FAST_BUDGET) begin
                    @(negedge clk);
                    k++;
                end
                if (conv_starts < base + i + 1)
                    check("avg_conv_timeout", 0, 1);
                target = 100 + i;
            end
            finish_conv(d0, 4 * FAST_BUDGET, lat);
        end
`else
        // Mid-range target, with latency bounded by the fast DAC period.
        d0 = done_count;
        start_conv(300, 300);
        finish_conv(d0, FAST_BUDGET, lat);
        check("lat_fast_min", 32'(lat > 9 * 512), 1);
        check("lat_fast_max", 32'(lat < 9 * 2048), 1);
        check("trial_count_300", 32'(trial_log.size()), 9);

        d0 = done_count;
        start_conv(0, 0);
        finish_conv(d0, FAST_BUDGET, lat);
        check("first_trial_0", 32'(trial_log[0]), 256);

        d0 = done_count;
        start_conv(511, 511);
        finish_conv(d0, FAST_BUDGET, lat);
        check("trial0_511", 32'(trial_log[0]), 256);
        check("trial1_511", 32'(trial_log[1]), 384);
        check("trial2_511", 32'(trial_log[2]), 448);
        check("trial_last_511", 32'(trial_log[trial_log.size() - 1]), 511);

        // A second start while converting must be ignored.
        d0 = done_count;
        start_conv(300, 300);
        wait_trials(5);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        finish_conv(d0, FAST_BUDGET, lat);

        // Reset during SETTLE aborts with no done.
        d0 = done_count;
        start_conv(300, 300);
        wait_trials(3);
        check("pre_reset_settle", 32'(dut.state), 32'(SETTLE));
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        sb.delete();
        check_reset_state("abort");
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_count - d0), 0);

        d0 = done_count;
        start_conv(123, 123);
        finish_conv(d0, FAST_BUDGET, lat);

        // Slow DAC: zero is high for 4 clocks per period and must count once.
        dac_slow = 1'b1;
        d0 = done_count;
        start_conv(200, 200);
        finish_conv(d0, SLOW_BUDGET, lat);
        check("lat_slow_min", 32'(lat > 9 * 2048), 1);
`endif

        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
